// File: rtl/lstm_run_ctrl_if.sv
// lstm_run_ctrl_if
//   Bundles the host run/busy handshake and the per-channel compute signals
//   of lstm_run_ctrl.
//   master : host / compute-channel side (drives run, mask, done, limit)
//   slave  : the run controller (drives start, busy, done pulse, status)
//   Signals:
//     dut_xxx_run    run request
//     ch_enable      channel participation mask
//     ch_done        per-channel completion
//     timeout_limit  watchdog limit in cycles, 0 disables
//     ch_start       per-channel one-cycle start pulse
//     ch_busy        per-channel busy
//     dut_xxx_busy   run in progress
//     all_done       one-cycle end-of-run pulse
//     timeout_err    last run ended by watchdog
//     cycle_count    cycles spent in the current/last run
interface lstm_run_ctrl_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16
);
   logic                dut_xxx_run;
   logic [NUM_CH-1:0]   ch_enable;
   logic [NUM_CH-1:0]   ch_done;
   logic [CNT_W-1:0]    timeout_limit;
   logic [NUM_CH-1:0]   ch_start;
   logic [NUM_CH-1:0]   ch_busy;
   logic                dut_xxx_busy;
   logic                all_done;
   logic                timeout_err;
   logic [CNT_W-1:0]    cycle_count;

   modport master (
      output dut_xxx_run, ch_enable, ch_done, timeout_limit,
      input  ch_start, ch_busy, dut_xxx_busy, all_done, timeout_err, cycle_count
   );

   modport slave (
      input  dut_xxx_run, ch_enable, ch_done, timeout_limit,
      output ch_start, ch_busy, dut_xxx_busy, all_done, timeout_err, cycle_count
   );
endinterface

// File: rtl/lstm_run_ctrl.sv
// lstm_run_ctrl
//   Multi-channel run/busy controller for the LSTM datapath. Accepts a run
//   request in IDLE, pulses ch_start to every enabled channel, tracks which
//   channels are still pending, and ends the run when all have reported done
//   or the watchdog limit is reached. Reports the run length and whether the
//   last run timed out.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    lstm_run_ctrl_if slave modport (run/busy handshake, channel
//            start/busy/done, watchdog limit, status)
module lstm_run_ctrl #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   lstm_run_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      RUN,
      FINISH
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_CH-1:0]   pending_q, pending_d;
   logic [NUM_CH-1:0]   next_pending;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    cnt_inc;
   logic                terr_q, terr_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         cnt_q     <= '0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         terr_q    <= terr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      cnt_d        = cnt_q;
      terr_d       = terr_q;
      next_pending = pending_q & ~bus.ch_done;
      // Saturating increment: the count sticks at all-ones on very long runs.
      cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            if (bus.dut_xxx_run) begin
               state_d   = START;
               pending_d = bus.ch_enable;
               cnt_d     = '0;
               terr_d    = 1'b0;
            end
         end
         START, RUN: begin
            pending_d = next_pending;
            cnt_d     = cnt_inc;
            // Completion is tested first so it wins a tie with the watchdog.
            if (next_pending == '0) begin
               state_d = FINISH;
            end else if ((bus.timeout_limit != '0) && (cnt_inc == bus.timeout_limit)) begin
               state_d = FINISH;
               terr_d  = 1'b1;
            end else begin
               state_d = RUN;
            end
         end
         FINISH: begin
            pending_d = '0;
            state_d   = IDLE;
         end
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase
   end

   assign bus.ch_start     = (state_q == START) ? pending_q : '0;
   assign bus.ch_busy      = ((state_q == START) || (state_q == RUN)) ? pending_q : '0;
   assign bus.dut_xxx_busy = (state_q == START) || (state_q == RUN);
   assign bus.all_done     = (state_q == FINISH);
   assign bus.timeout_err  = terr_q;
   assign bus.cycle_count  = cnt_q;

endmodule

// File: tb/tb_lstm_run_ctrl.sv
// tb_lstm_run_ctrl
//   Randomised and directed stimulus for lstm_run_ctrl. Each run is described
//   by its mask, watchdog limit and the cycle offset at which each channel
//   first reports done; the expected outputs are derived from those numbers
//   and queued, and a negedge monitor pops and compares them.
module tb_lstm_run_ctrl;
   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned NEVER  = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lstm_run_ctrl_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus_if ();

   lstm_run_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   typedef struct packed {
      logic [NUM_CH-1:0] st;
      logic [NUM_CH-1:0] cb;
      logic              bsy;
      logic              dn;
      logic [CNT_W-1:0]  cnt;
      logic              te;
   } exp_t;

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic             te;
   } run_t;

   exp_t cyc_q[$];
   run_t run_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [CNT_W-1:0] last_cnt = '0;
   logic             last_te  = 1'b0;

   task automatic expect_cycle(input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] cb,
                               input logic bsy, input logic dn,
                               input logic [CNT_W-1:0] cnt, input logic te);
      exp_t e;
      e.st = st; e.cb = cb; e.bsy = bsy; e.dn = dn; e.cnt = cnt; e.te = te;
      cyc_q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         next_cycle();
         bus_if.dut_xxx_run = 1'b0;
         bus_if.ch_done     = NUM_CH'($urandom);
         bus_if.ch_enable   = NUM_CH'($urandom);
         expect_cycle('0, '0, 1'b0, 1'b0, last_cnt, last_te);
      end
   endtask

   // One run: accepted in the first driven cycle, then START/RUN cycles
   // 1..e, then FINISH. A channel with done offset k is busy through cycle k.
   task automatic do_run(input logic [NUM_CH-1:0] en, input logic [CNT_W-1:0] lim,
                         input int unsigned off [NUM_CH], input int unsigned abort_in,
                         input logic run_in_finish);
      int unsigned d, e, abort_at;
      logic te;
      logic [NUM_CH-1:0] pend, dn;
      run_t r;
      d = 1;
      for (int unsigned i = 0; i < NUM_CH; i++)
         if (en[i] && off[i] > d) d = off[i];
      if (lim == '0 || d <= int'(lim)) begin
         e = d; te = 1'b0;
      end else begin
         e = int'(lim); te = 1'b1;
      end
      abort_at = (abort_in > e) ? e : abort_in;

      next_cycle();
      bus_if.dut_xxx_run   = 1'b1;
      bus_if.ch_enable     = en;
      bus_if.timeout_limit = lim;
      bus_if.ch_done       = NUM_CH'($urandom);
      expect_cycle('0, '0, 1'b0, 1'b0, last_cnt, last_te);
      if (abort_at == 0) begin
         r.cnt = CNT_W'(e); r.te = te;
         run_q.push_back(r);
      end

      for (int unsigned k = 1; k <= e; k++) begin
         next_cycle();
         pend = '0; dn = '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (en[i]) begin
               pend[i] = (off[i] >= k);
               dn[i]   = (k == off[i]) || (k > off[i] && $urandom_range(0, 1) == 1);
            end else begin
               dn[i]   = ($urandom_range(0, 1) == 1);
            end
         end
         bus_if.dut_xxx_run = 1'($urandom_range(0, 1));
         bus_if.ch_enable   = NUM_CH'($urandom);
         bus_if.ch_done     = dn;
         reset              = (k == abort_at);
         expect_cycle((k == 1) ? en : '0, pend, 1'b1, 1'b0, CNT_W'(k - 1), 1'b0);
         if (k == abort_at) begin
            next_cycle();
            bus_if.dut_xxx_run = 1'b0;
            expect_cycle('0, '0, 1'b0, 1'b0, '0, 1'b0);
            next_cycle();
            reset = 1'b0;
            expect_cycle('0, '0, 1'b0, 1'b0, '0, 1'b0);
            last_cnt = '0;
            last_te  = 1'b0;
            return;
         end
      end

      next_cycle();
      bus_if.dut_xxx_run = run_in_finish;
      bus_if.ch_done     = NUM_CH'($urandom);
      reset              = 1'b0;
      expect_cycle('0, '0, 1'b0, 1'b1, CNT_W'(e), te);
      last_cnt = CNT_W'(e);
      last_te  = te;
   endtask

   // Monitor: compares every cycle's outputs, and the run summary on all_done.
   always @(negedge clk) begin
      exp_t e, a;
      run_t r;
      if (cyc_q.size() > 0) begin
         e = cyc_q.pop_front();
         a.st = bus_if.ch_start; a.cb = bus_if.ch_busy; a.bsy = bus_if.dut_xxx_busy;
         a.dn = bus_if.all_done; a.cnt = bus_if.cycle_count; a.te = bus_if.timeout_err;
         n_checks++;
         if (a === e) n_pass++;
         else $display("FAIL cycle_outputs t=%0t: actual start=%b busy=%b run_busy=%b done=%b cnt=%0d terr=%b required start=%b busy=%b run_busy=%b done=%b cnt=%0d terr=%b",
                       $time, a.st, a.cb, a.bsy, a.dn, a.cnt, a.te, e.st, e.cb, e.bsy, e.dn, e.cnt, e.te);
      end
      if (bus_if.all_done === 1'b1) begin
         n_checks++;
         if (run_q.size() == 0) begin
            $display("FAIL run_end t=%0t: actual all_done=1 required no run outstanding", $time);
         end else begin
            r = run_q.pop_front();
            if (bus_if.cycle_count === r.cnt && bus_if.timeout_err === r.te) n_pass++;
            else $display("FAIL run_end t=%0t: actual cnt=%0d terr=%b required cnt=%0d terr=%b",
                          $time, bus_if.cycle_count, bus_if.timeout_err, r.cnt, r.te);
         end
      end
   end

   initial begin
      #(10 * 100000);
      $display("FAIL watchdog: actual simulation still running required finish");
      $fatal(1);
   end

   initial begin
      int unsigned off [NUM_CH];
      logic [CNT_W-1:0] lim;
      int unsigned ab;

      reset                = 1'b1;
      bus_if.dut_xxx_run   = 1'b0;
      bus_if.ch_enable     = '0;
      bus_if.ch_done       = '0;
      bus_if.timeout_limit = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      expect_cycle('0, '0, 1'b0, 1'b0, '0, 1'b0);
      idle_cycles(2);

      // Staggered completion on mask 1011.
      off = '{2, 6, NEVER, 4};
      do_run(4'b1011, '0, off, 0, 1'b0);
      idle_cycles(1);

      // Both channels done in START; run in FINISH ignored, next run accepted.
      off = '{1, 1, NEVER, NEVER};
      do_run(4'b0011, '0, off, 0, 1'b1);

      // Watchdog timeout, then a run that clears timeout_err.
      off = '{NEVER, NEVER, NEVER, NEVER};
      do_run(4'b0001, 16'd5, off, 0, 1'b0);
      idle_cycles(2);
      off = '{3, NEVER, NEVER, NEVER};
      do_run(4'b0001, 16'd3, off, 0, 1'b0);   // completion ties watchdog
      idle_cycles(1);

      // Empty mask, then a long run with the watchdog disabled.
      do_run(4'b0000, '0, off, 0, 1'b0);
      off = '{1000, NEVER, NEVER, NEVER};
      do_run(4'b0001, '0, off, 0, 1'b0);
      idle_cycles(1);

      // Reset in the middle of a run, then a normal run.
      off = '{8, 8, 8, 8};
      do_run(4'b1111, '0, off, 3, 1'b0);
      idle_cycles(1);
      off = '{2, 3, 4, 5};
      do_run(4'b1111, '0, off, 0, 1'b0);

      for (int unsigned n = 0; n < 60; n++) begin
         for (int unsigned i = 0; i < NUM_CH; i++) off[i] = $urandom_range(1, 15);
         lim = ($urandom_range(0, 2) == 0) ? '0 : CNT_W'($urandom_range(1, 12));
         ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0;
         do_run(NUM_CH'($urandom), lim, off, ab, 1'($urandom_range(0, 1)));
         idle_cycles($urandom_range(0, 2));
      end

      idle_cycles(2);
      repeat (3) @(negedge clk);
      n_checks++;
      if (cyc_q.size() == 0 && run_q.size() == 0) n_pass++;
      else $display("FAIL queues_drained: actual cycle=%0d runs=%0d required 0 and 0",
                    cyc_q.size(), run_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
